// File: rtl/sipo_stereo_rx.sv
// sipo_stereo_rx: serial-to-parallel stereo input receiver.
// Captures MSB-first left/right sample words framed by a shared Frame strobe
// and hands each completed pair to the consumer through a level-ready,
// acknowledge-cleared handshake.
// Optional build macro: SIPO_RX_OVERRUN_EN enables the sticky overrun flag;
// without it the overrun output is tied low.
module sipo_stereo_rx #(
    parameter int DATA_W = 16
) (
    input  logic              Sclk,
    input  logic              Clear,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] DataL,
    output logic [DATA_W-1:0] DataR,
    output logic              InReady,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q,     state_d;
    logic [DATA_W-1:0]  sh_l_q,      sh_l_d;
    logic [DATA_W-1:0]  sh_r_q,      sh_r_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DATA_W-1:0]  data_l_q,    data_l_d;
    logic [DATA_W-1:0]  data_r_q,    data_r_d;
    logic               in_ready_q,  in_ready_d;
    logic               frame_err_q, frame_err_d;
    logic               complete;

`ifdef SIPO_RX_OVERRUN_EN
    logic               overrun_q,   overrun_d;
`endif

    // Next-state logic: framing, shifting, completion and handshake.
    always_comb begin
        state_d     = state_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        cnt_d       = cnt_q;
        data_l_d    = data_l_q;
        data_r_d    = data_r_q;
        in_ready_d  = in_ready_q;
        frame_err_d = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Frame) begin
                    sh_l_d  = {{(DATA_W-1){1'b0}}, InputL};
                    sh_r_d  = {{(DATA_W-1){1'b0}}, InputR};
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (Frame) begin
                    // A mid-word Frame restarts the word; it outranks completion.
                    frame_err_d = 1'b1;
                    sh_l_d      = {{(DATA_W-1){1'b0}}, InputL};
                    sh_r_d      = {{(DATA_W-1){1'b0}}, InputR};
                    cnt_d       = CNT_LOAD;
                end else begin
                    sh_l_d = {sh_l_q[DATA_W-2:0], InputL};
                    sh_r_d = {sh_r_q[DATA_W-2:0], InputR};
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Acknowledge clears ready, but a completion on the same edge wins.
        if (rd_ack) begin
            in_ready_d = 1'b0;
        end
        if (complete) begin
            data_l_d   = sh_l_d;
            data_r_d   = sh_r_d;
            in_ready_d = 1'b1;
        end
    end

`ifdef SIPO_RX_OVERRUN_EN
    // Sticky overrun: a new pair lands while the previous one is unacknowledged.
    always_comb begin
        overrun_d = overrun_q;
        if (complete && in_ready_q && !rd_ack) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun flag register; only Clear releases it.
    always_ff @(posedge Sclk) begin
        if (Clear) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    // State and datapath registers with synchronous clear.
    always_ff @(posedge Sclk) begin
        if (Clear) begin
            state_q     <= IDLE;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            cnt_q       <= '0;
            data_l_q    <= '0;
            data_r_q    <= '0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            cnt_q       <= cnt_d;
            data_l_q    <= data_l_d;
            data_r_q    <= data_r_d;
            in_ready_q  <= in_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign DataL     = data_l_q;
    assign DataR     = data_r_q;
    assign InReady   = in_ready_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_stereo_rx.sv
// tb_sipo_stereo_rx: directed bench for sipo_stereo_rx at DATA_W = 16.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_sipo_stereo_rx;

    localparam int W = 16;

    logic         Sclk;
    logic         Clear;
    logic         Frame;
    logic         InputL;
    logic         InputR;
    logic         rd_ack;
    logic [W-1:0] DataL;
    logic [W-1:0] DataR;
    logic         InReady;
    logic         frame_err;
    logic         overrun;

    int n_checks;
    int n_fail;

    logic exp_ovr;
    logic ferr_first;
    logic ferr_later;
    logic rdy_early;

    sipo_stereo_rx #(.DATA_W(W)) dut (
        .Sclk      (Sclk),
        .Clear     (Clear),
        .Frame     (Frame),
        .InputL    (InputL),
        .InputR    (InputR),
        .rd_ack    (rd_ack),
        .DataL     (DataL),
        .DataR     (DataR),
        .InReady   (InReady),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        Sclk = 1'b0;
        forever #5 Sclk = ~Sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, wait for the edge, settle past it.
    task automatic tick(input logic f, input logic l, input logic r,
                        input logic ack, input logic clr);
        Frame  = f;
        InputL = l;
        InputR = r;
        rd_ack = ack;
        Clear  = clr;
        @(posedge Sclk);
        #1;
        Frame  = 1'b0;
        rd_ack = 1'b0;
        Clear  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends the top nbits of a word pair, Frame on the first bit.
    task automatic send_bits(input logic [W-1:0] wl, input logic [W-1:0] wr, input int nbits);
        for (int i = W - 1; i >= W - nbits; i--)
            tick(i == W - 1, wl[i], wr[i], 1'b0, 1'b0);
    endtask

    // Sends a full word pair; rd_ack is raised on bit index ack_idx (-1 = never).
    task automatic send_word(input logic [W-1:0] wl, input logic [W-1:0] wr,
                             input int ack_idx,
                             output logic f_first, output logic f_later,
                             output logic r_early);
        f_first = 1'b0;
        f_later = 1'b0;
        r_early = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            tick(i == W - 1, wl[i], wr[i], i == ack_idx, 1'b0);
            if (i == W - 1) f_first = frame_err;
            else            f_later = f_later | frame_err;
            if (i != 0)     r_early = r_early | InReady;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef SIPO_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        Frame = 1'b0; InputL = 1'b0; InputR = 1'b0; rd_ack = 1'b0; Clear = 1'b0;

        // Reset state
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("rst_datal",   DataL,     32'h0);
        chk("rst_datar",   DataR,     32'h0);
        chk("rst_ready",   InReady,   32'h0);
        chk("rst_ferr",    frame_err, 32'h0);
        chk("rst_overrun", overrun,   32'h0);

        // Single word pair, then acknowledge
        idle(3);
        send_word(16'hA5C3, 16'h1234, -1, ferr_first, ferr_later, rdy_early);
        chk("w1_early_ready", rdy_early, 32'h0);
        chk("w1_ready",       InReady,   32'h1);
        chk("w1_datal",       DataL,     32'hA5C3);
        chk("w1_datar",       DataR,     32'h1234);
        chk("w1_ferr",        ferr_first | ferr_later | frame_err, 32'h0);
        idle(4);
        chk("w1_ready_hold",  InReady,   32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("w1_ack",         InReady,   32'h0);
        chk("w1_data_hold",   DataL,     32'hA5C3);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ack_idle_ready", InReady,   32'h0);

        // Back-to-back words; ack on the second bit of the second word
        send_word(16'hFFFF, 16'h0F0F, -1, ferr_first, ferr_later, rdy_early);
        chk("b2b_datal0", DataL,   32'hFFFF);
        chk("b2b_datar0", DataR,   32'h0F0F);
        chk("b2b_ready0", InReady, 32'h1);
        chk("b2b_ferr0",  ferr_first | ferr_later, 32'h0);
        send_word(16'h0001, 16'h8000, W - 2, ferr_first, ferr_later, rdy_early);
        chk("b2b_datal1", DataL,   32'h0001);
        chk("b2b_datar1", DataR,   32'h8000);
        chk("b2b_ready1", InReady, 32'h1);
        chk("b2b_ferr1",  ferr_first | ferr_later, 32'h0);
        chk("b2b_ovr",    overrun, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b_ack",    InReady, 32'h0);

        // Frame error: restart after 7 bits with 0xBEEF
        send_bits(16'h1234, 16'h4321, 7);
        chk("ferr_pre",   frame_err, 32'h0);
        send_word(16'hBEEF, 16'hCAFE, -1, ferr_first, ferr_later, rdy_early);
        chk("ferr_pulse", ferr_first, 32'h1);
        chk("ferr_once",  ferr_later, 32'h0);
        chk("ferr_nodel", rdy_early,  32'h0);
        chk("ferr_datal", DataL,      32'hBEEF);
        chk("ferr_datar", DataR,      32'hCAFE);
        chk("ferr_ready", InReady,    32'h1);

        // Completion and ack on the same edge: stays ready, no overrun
        send_word(16'h2468, 16'h1357, 0, ferr_first, ferr_later, rdy_early);
        chk("same_ready", InReady, 32'h1);
        chk("same_datal", DataL,   32'h2468);
        chk("same_ovr",   overrun, 32'h0);

        // Completion while still ready, no ack: overwrite (+ overrun if built)
        send_word(16'h1357, 16'h9BDF, -1, ferr_first, ferr_later, rdy_early);
        chk("ovr_datal", DataL,   32'h1357);
        chk("ovr_datar", DataR,   32'h9BDF);
        chk("ovr_ready", InReady, 32'h1);
        chk("ovr_flag",  overrun, {31'h0, exp_ovr});
        idle(3);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_sticky", overrun, {31'h0, exp_ovr});

        // Clear mid-word, then a fresh word
        send_bits(16'hDEAD, 16'hF00D, 8);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_datal",  DataL,   32'h0);
        chk("clr_ready",  InReady, 32'h0);
        chk("clr_ovr",    overrun, 32'h0);
        idle(3);
        send_word(16'h00FF, 16'hFF00, -1, ferr_first, ferr_later, rdy_early);
        chk("clr_nodel",  rdy_early, 32'h0);
        chk("clr_ferr",   ferr_first | ferr_later, 32'h0);
        chk("clr_datal2", DataL,   32'h00FF);
        chk("clr_datar2", DataR,   32'hFF00);
        chk("clr_ready2", InReady, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
